// File: rtl/mult_bist_pkg.sv
// rtl/mult_bist_pkg.sv - shared types and MISR constants for the multiplier BIST controller
package mult_bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam int MISR_TAP0 = 15;
  localparam int MISR_TAP1 = 13;
  localparam int MISR_TAP2 = 12;
  localparam int MISR_TAP3 = 10;

  localparam logic [15:0] MISR_SEED = 16'h0000;

endpackage

// File: rtl/mult_bist_misr.sv
// rtl/mult_bist_misr.sv - multiple-input signature register compacting captured results
module mult_bist_misr
  import mult_bist_pkg::*;
#(
  parameter int SIG_WIDTH = 16,
  parameter int DIN_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic [DIN_WIDTH-1:0] din,
  output logic [SIG_WIDTH-1:0] sig
);

  logic [SIG_WIDTH-1:0] sig_q;
  logic [SIG_WIDTH-1:0] sig_d;
  logic                 fb;

  // Next signature: clear reloads the seed, en shifts in feedback and folds in din
  always_comb begin
    fb    = sig_q[MISR_TAP0] ^ sig_q[MISR_TAP1] ^ sig_q[MISR_TAP2] ^ sig_q[MISR_TAP3];
    sig_d = sig_q;
    if (clear) begin
      sig_d = SIG_WIDTH'(MISR_SEED);
    end else if (en) begin
      sig_d = {sig_q[SIG_WIDTH-2:0], fb} ^ SIG_WIDTH'(din);
    end
  end

  // Signature register
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/mult_bist_ctrl.sv
// rtl/mult_bist_ctrl.sv - BIST sequencer: walks operands, captures results, compacts a signature
module mult_bist_ctrl
  import mult_bist_pkg::*;
#(
  parameter int BIT_WIDTH     = 2,
  parameter int OUT_WIDTH     = BIT_WIDTH + 8,
  parameter int NUM_VECTORS   = 16,
  parameter int SETTLE_CYCLES = 1,
  parameter int SIG_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [BIT_WIDTH-1:0] dut_inp,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 cap_valid,
  output logic [OUT_WIDTH-1:0] cap_data,
  input  logic                 cap_ready,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_WIDTH-1:0] signature
);

  localparam int CNT_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     vec_cnt_q, vec_cnt_d;
  logic [SET_W-1:0]     settle_cnt_q, settle_cnt_d;
  logic [BIT_WIDTH-1:0] dut_inp_q, dut_inp_d;
  logic                 cap_valid_q, cap_valid_d;
  logic [OUT_WIDTH-1:0] cap_data_q, cap_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 misr_clear;
  logic                 misr_en;

  // Sequencer next-state: start only honoured when not busy; capture waits on handshake
  always_comb begin
    state_d      = state_q;
    vec_cnt_d    = vec_cnt_q;
    settle_cnt_d = settle_cnt_q;
    dut_inp_d    = dut_inp_q;
    cap_valid_d  = cap_valid_q;
    cap_data_d   = cap_data_q;
    busy_d       = busy_q;
    done_d       = done_q;
    misr_clear   = 1'b0;
    misr_en      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = SETTLE;
          vec_cnt_d    = '0;
          settle_cnt_d = '0;
          dut_inp_d    = '0;
          done_d       = 1'b0;
          busy_d       = 1'b1;
          misr_clear   = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d      = CAPTURE;
          settle_cnt_d = '0;
          cap_data_d   = dut_out;
          cap_valid_d  = 1'b1;
          misr_en      = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        if (cap_valid_q && cap_ready) begin
          cap_valid_d = 1'b0;
          if (vec_cnt_q == CNT_W'(NUM_VECTORS - 1)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d   = SETTLE;
            vec_cnt_d = vec_cnt_q + 1'b1;
            // dut_inp tracks vec_cnt modulo 2^BIT_WIDTH, so incrementing it wraps naturally
            dut_inp_d = dut_inp_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and output registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_cnt_q    <= '0;
      settle_cnt_q <= '0;
      dut_inp_q    <= '0;
      cap_valid_q  <= 1'b0;
      cap_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_cnt_q    <= vec_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      dut_inp_q    <= dut_inp_d;
      cap_valid_q  <= cap_valid_d;
      cap_data_q   <= cap_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  mult_bist_misr #(
    .SIG_WIDTH(SIG_WIDTH),
    .DIN_WIDTH(OUT_WIDTH)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .clear(misr_clear),
    .en   (misr_en),
    .din  (dut_out),
    .sig  (signature)
  );

  assign dut_inp   = dut_inp_q;
  assign cap_valid = cap_valid_q;
  assign cap_data  = cap_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mult_bist_ctrl.sv
// tb/tb_mult_bist_ctrl.sv - scoreboard bench for mult_bist_ctrl with a sign-extending stub DUT
module tb_mult_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Instance with NUM_VECTORS=4
  logic       start4 = 1'b0;
  logic [1:0] dut_inp4;
  logic [9:0] dut_out4;
  logic       cap_valid4;
  logic [9:0] cap_data4;
  logic       cap_ready4 = 1'b1;
  logic       busy4;
  logic       done4;
  logic [15:0] sig4;

  // Instance with NUM_VECTORS=6
  logic       start6 = 1'b0;
  logic [1:0] dut_inp6;
  logic [9:0] dut_out6;
  logic       cap_valid6;
  logic [9:0] cap_data6;
  logic       cap_ready6 = 1'b1;
  logic       busy6;
  logic       done6;
  logic [15:0] sig6;

  assign dut_out4 = {{8{dut_inp4[1]}}, dut_inp4};
  assign dut_out6 = {{8{dut_inp6[1]}}, dut_inp6};

  mult_bist_ctrl #(
    .BIT_WIDTH(2), .OUT_WIDTH(10), .NUM_VECTORS(4), .SETTLE_CYCLES(1), .SIG_WIDTH(16)
  ) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .dut_inp(dut_inp4), .dut_out(dut_out4),
    .cap_valid(cap_valid4), .cap_data(cap_data4), .cap_ready(cap_ready4),
    .busy(busy4), .done(done4), .signature(sig4)
  );

  mult_bist_ctrl #(
    .BIT_WIDTH(2), .OUT_WIDTH(10), .NUM_VECTORS(6), .SETTLE_CYCLES(1), .SIG_WIDTH(16)
  ) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .dut_inp(dut_inp6), .dut_out(dut_out6),
    .cap_valid(cap_valid6), .cap_data(cap_data6), .cap_ready(cap_ready6),
    .busy(busy6), .done(done6), .signature(sig6)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] sext(input int v);
    logic [1:0] b;
    b = v[1:0];
    return {{8{b[1]}}, b};
  endfunction

  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [9:0] d);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb} ^ {6'b0, d};
  endfunction

  logic [9:0] exp_data4[$];
  logic [1:0] exp_inp4[$];
  logic [9:0] exp_data6[$];
  logic [1:0] exp_inp6[$];
  int cap_cnt4 = 0;
  int cap_cnt6 = 0;

  // Scoreboard pop for the 4-vector instance on each accepted capture
  always @(negedge clk) begin
    if (!rst && cap_valid4 && cap_ready4) begin
      check("sb4_avail", 32'(exp_data4.size() != 0), 32'd1);
      if (exp_data4.size() != 0) begin
        check("cap_data4", 32'(cap_data4), 32'(exp_data4.pop_front()));
        check("dut_inp4", 32'(dut_inp4), 32'(exp_inp4.pop_front()));
      end
      cap_cnt4++;
    end
  end

  // Scoreboard pop for the 6-vector instance
  always @(negedge clk) begin
    if (!rst && cap_valid6 && cap_ready6) begin
      check("sb6_avail", 32'(exp_data6.size() != 0), 32'd1);
      if (exp_data6.size() != 0) begin
        check("cap_data6", 32'(cap_data6), 32'(exp_data6.pop_front()));
        check("dut_inp6", 32'(dut_inp6), 32'(exp_inp6.pop_front()));
      end
      cap_cnt6++;
    end
  end

  // One run on the 4-vector instance; optional stall of a given capture and a mid-run start pulse
  task automatic run4(input string tag, input int stall_at, input int stall_len,
                      input int mid_start, output int cycles);
    int stalled;
    @(posedge clk); #1;
    start4 = 1'b1;
    cap_ready4 = 1'b1;
    cap_cnt4 = 0;
    for (int i = 0; i < 4; i++) begin
      exp_data4.push_back(sext(i));
      exp_inp4.push_back(2'(i));
    end
    @(posedge clk); #1;
    start4 = 1'b0;
    check({tag, "_start_done"}, 32'(done4), 32'd0);
    check({tag, "_start_busy"}, 32'(busy4), 32'd1);
    check({tag, "_start_seed"}, 32'(sig4), 32'd0);
    cycles = 1;
    stalled = 0;
    while (!done4 && cycles < 200) begin
      if (cap_valid4 && cap_cnt4 == stall_at && stalled < stall_len) begin
        cap_ready4 = 1'b0;
        stalled++;
        check({tag, "_stall_valid"}, 32'(cap_valid4), 32'd1);
        check({tag, "_stall_data"}, 32'(cap_data4), 32'(sext(stall_at)));
      end else begin
        cap_ready4 = 1'b1;
      end
      start4 = (cycles == mid_start);
      @(posedge clk); #1;
      cycles++;
    end
    start4 = 1'b0;
    cap_ready4 = 1'b1;
    check({tag, "_caps"}, 32'(cap_cnt4), 32'd4);
    check({tag, "_sig"}, 32'(sig4), 32'h0407);
    check({tag, "_busy_end"}, 32'(busy4), 32'd0);
  endtask

  int cyc;
  int guard;
  logic [15:0] exp_sig6;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cap_valid", 32'(cap_valid4), 32'd0);
    check("rst_cap_data", 32'(cap_data4), 32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_sig", 32'(sig4), 32'd0);
    check("rst_dut_inp", 32'(dut_inp4), 32'd0);
    rst = 1'b0;

    // Free-flowing run: done 9 cycles after start
    run4("basic", -1, 0, 0, cyc);
    check("basic_latency", 32'(cyc), 32'd9);
    check("basic_done", 32'(done4), 32'd1);

    // Start from DONE reseeds and repeats exactly
    run4("rerun", -1, 0, 0, cyc);
    check("rerun_latency", 32'(cyc), 32'd9);

    // Backpressure at the second capture for 5 cycles
    run4("stall", 1, 5, 0, cyc);
    check("stall_latency", 32'(cyc), 32'd14);

    // Start pulsed while busy is ignored
    run4("midstart", -1, 0, 3, cyc);
    check("midstart_latency", 32'(cyc), 32'd9);

    // Reset while vector 2 is in CAPTURE
    @(posedge clk); #1;
    start4 = 1'b1;
    cap_cnt4 = 0;
    for (int i = 0; i < 4; i++) begin
      exp_data4.push_back(sext(i));
      exp_inp4.push_back(2'(i));
    end
    @(posedge clk); #1;
    start4 = 1'b0;
    guard = 0;
    while (!(cap_valid4 && cap_cnt4 == 2) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("rstmid_reached", 32'(guard < 100), 32'd1);
    check("rstmid_data", 32'(cap_data4), 32'(sext(2)));
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_cap_valid", 32'(cap_valid4), 32'd0);
    check("rstmid_cap_data", 32'(cap_data4), 32'd0);
    check("rstmid_busy", 32'(busy4), 32'd0);
    check("rstmid_done", 32'(done4), 32'd0);
    check("rstmid_sig", 32'(sig4), 32'd0);
    check("rstmid_dut_inp", 32'(dut_inp4), 32'd0);
    check("rstmid_caps", 32'(cap_cnt4), 32'd2);
    rst = 1'b0;
    exp_data4.delete();
    exp_inp4.delete();
    run4("afterrst", -1, 0, 0, cyc);
    check("afterrst_latency", 32'(cyc), 32'd9);

    // Six vectors: operand wraps, done after 13 cycles
    exp_sig6 = 16'h0000;
    @(posedge clk); #1;
    start6 = 1'b1;
    cap_cnt6 = 0;
    for (int i = 0; i < 6; i++) begin
      exp_data6.push_back(sext(i % 4));
      exp_inp6.push_back(2'(i % 4));
      exp_sig6 = misr_model(exp_sig6, sext(i % 4));
    end
    @(posedge clk); #1;
    start6 = 1'b0;
    cyc = 1;
    while (!done6 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("nv6_latency", 32'(cyc), 32'd13);
    check("nv6_caps", 32'(cap_cnt6), 32'd6);
    check("nv6_sig", 32'(sig6), 32'(exp_sig6));

    check("sb4_empty", 32'(exp_data4.size()), 32'd0);
    check("sb6_empty", 32'(exp_data6.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_bist_ctrl.md
MULT_BIST_CTRL -- requirements
Module: mult_bist_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 2, meaning DUT operand width in bits (signed).
REQ-002 SHALL have parameter OUT_WIDTH, default BIT_WIDTH+8, meaning DUT result width in bits (signed).
REQ-003 SHALL have parameter NUM_VECTORS, default 16, meaning vectors applied per run (>=1).
REQ-004 SHALL have parameter SETTLE_CYCLES, default 1, meaning cycles each vector is held before sampling (>=1).
REQ-005 SHALL have parameter SIG_WIDTH, default 16, meaning signature width (>= OUT_WIDTH).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, single-cycle request to begin a run.
REQ-009 SHALL have port dut_inp, output, BIT_WIDTH, registered operand driven to the DUT.
REQ-010 SHALL have port dut_out, input, OUT_WIDTH, DUT result (combinational function of dut_inp).
REQ-011 SHALL have port cap_valid, output, 1, captured result available.
REQ-012 SHALL have port cap_data, output, OUT_WIDTH, captured result.
REQ-013 SHALL have port cap_ready, input, 1, downstream sink accepts cap_data.
REQ-014 SHALL have port busy, output, 1, run in progress.
REQ-015 SHALL have port done, output, 1, run complete; held until next start or reset.
REQ-016 SHALL have port signature, output, SIG_WIDTH, MISR compaction of all captured results.

Function
REQ-017 SHALL implement states IDLE, SETTLE, CAPTURE, DONE.
REQ-018 start in IDLE or DONE SHALL, at that edge: vec_cnt=0, dut_inp=0, signature=seed 0, done=0, busy=1, settle count cleared, next state SETTLE.
REQ-019 start while busy SHALL be ignored.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles with dut_inp stable, then go to CAPTURE.
REQ-021 On the SETTLE->CAPTURE edge, cap_data SHALL register dut_out and signature SHALL update once with that value.
REQ-022 In CAPTURE, cap_valid SHALL be 1 and cap_data/signature held until cap_valid&&cap_ready.
REQ-023 On handshake with vec_cnt<NUM_VECTORS-1: vec_cnt+1, dut_inp = (vec_cnt+1) mod 2^BIT_WIDTH (wrap-around), state SETTLE, cap_valid 0.
REQ-024 On handshake with vec_cnt==NUM_VECTORS-1: state DONE, busy 0, done 1, cap_valid 0.
REQ-025 cap_ready while cap_valid=0 SHALL have no effect; cap_ready held low SHALL stall indefinitely with no lost or duplicate captures.
REQ-026 MISR update: fb = XOR of signature bits 15,13,12,10 (x^16+x^14+x^13+x^11+1); next = {signature[SIG_WIDTH-2:0], fb} XOR zero-extended dut_out.
REQ-027 With cap_ready tied 1, done SHALL assert NUM_VECTORS*(SETTLE_CYCLES+1)+1 cycles after the start edge.
REQ-028 vec_cnt SHALL be clog2(NUM_VECTORS) bits, never exceeding NUM_VECTORS-1.

Reset
REQ-029 rst SHALL dominate start and cap_ready, in any state, mid-run included.
REQ-030 Reset values: state IDLE, dut_inp 0, cap_valid 0, cap_data 0, busy 0, done 0, signature 0, counters 0.

Structure
REQ-031 Package mult_bist_pkg SHALL hold the state enum, MISR tap positions and seed constant.
REQ-032 The MISR SHALL be sub-module mult_bist_misr (clk, rst, clear, en, din, sig); all else in mult_bist_ctrl.

Verification (stub DUT: dut_out = sign-extended dut_inp; NUM_VECTORS=4, SETTLE_CYCLES=1 unless stated)
REQ-033 start, cap_ready=1 -> cap_data 0x000,0x001,0x3FE,0x3FF in order; done 9 cycles after start; signature 0x0407.
REQ-034 cap_ready low 5 cycles at second capture -> cap_valid held, cap_data 0x001 stable, same final sequence and signature 0x0407.
REQ-035 start pulsed again mid-run -> ignored; exactly 4 captures; signature 0x0407.
REQ-036 rst during CAPTURE of vector 2 -> next cycle all outputs at reset values; new start yields REQ-033 result.
REQ-037 NUM_VECTORS=6 -> dut_inp sequence 0,1,2,3,0,1 (wrap); done after 6*2+1=13 cycles.
REQ-038 start in DONE -> done clears, signature reseeds to 0, rerun repeats REQ-033 exactly.
